seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider.sv | 171 +++++++++++++++++
 tb/tb_seq_divider.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// seq_divider: radix-2 restoring divider, one quotient bit per clock.
// Define SEQ_DIVIDER_SIGNED_EN to honour signed_mode (two's complement).
module seq_divider #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         signed_mode,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] Q,
  output logic [N-1:0] R,
  output logic         dbz,
  output logic         ovf
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  quo_q, rem_q, div_q;
  logic [CW-1:0] cnt_q;
  logic          pend_q, pdbz_q;

  logic          accept, last;
  logic          is_dbz, is_ovf, special;
  logic [N-1:0]  a_mag, b_mag;
  logic [N-1:0]  q_fix, r_fix;
  logic [N:0]    sh;
  logic          ge;
  logic [N-1:0]  rem_nx;

  assign accept  = start && (state_q == IDLE);
  assign last    = (cnt_q == CW'(N-1));
  assign is_dbz  = (B == '0);
  assign special = is_dbz || is_ovf;
  assign busy    = (state_q != IDLE);

  assign sh     = {rem_q, quo_q[N-1]};
  assign ge     = (sh >= {1'b0, div_q});
  assign rem_nx = ge ? sh[N-1:0] - div_q
                     : sh[N-1:0];

`ifdef SEQ_DIVIDER_SIGNED_EN
  localparam logic [N-1:0] MIN =
    {1'b1, {(N-1){1'b0}}};

  logic a_neg, b_neg;
  logic q_neg_q, r_neg_q;
  logic ovf_q, povf_q;

  assign a_neg  = signed_mode && A[N-1];
  assign b_neg  = signed_mode && B[N-1];
  assign a_mag  = a_neg ? -A : A;
  assign b_mag  = b_neg ? -B : B;
  assign is_ovf = signed_mode
               && (A == MIN)
               && (B == '1);
  assign q_fix  = q_neg_q ? -quo_q : quo_q;
  assign r_fix  = r_neg_q ? -rem_q : rem_q;
  assign ovf    = ovf_q;

  // Result signs captured at acceptance; overflow flag tracks completions.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      ovf_q   <= 1'b0;
      povf_q  <= 1'b0;
    end else begin
      if (accept) begin
        q_neg_q <= a_neg ^ b_neg;
        r_neg_q <= a_neg;
        povf_q  <= is_ovf;
      end
      if (pend_q)
        ovf_q <= povf_q;
      else if (state_q == FIX)
        ovf_q <= 1'b0;
    end
  end
`else
  logic unused_sm;

  assign unused_sm = signed_mode;
  assign a_mag     = A;
  assign b_mag     = B;
  assign is_ovf    = 1'b0;
  assign q_fix     = quo_q;
  assign r_fix     = rem_q;
  assign ovf       = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // Next state: special operands never leave IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept && !special) state_d = RUN;
      RUN:  if (last) state_d = FIX;
      FIX:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: load, iterate, and publish results on completion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      quo_q  <= '0;
      rem_q  <= '0;
      div_q  <= '0;
      cnt_q  <= '0;
      pend_q <= 1'b0;
      pdbz_q <= 1'b0;
      done   <= 1'b0;
      Q      <= '0;
      R      <= '0;
      dbz    <= 1'b0;
    end else begin
      done   <= 1'b0;
      pend_q <= 1'b0;
      if (pend_q) begin
        done <= 1'b1;
        Q    <= quo_q;
        R    <= rem_q;
        dbz  <= pdbz_q;
      end
      if (accept) begin
        if (special) begin
          // Overflow quotient is -2^(N-1), which equals A itself.
          pend_q <= 1'b1;
          pdbz_q <= is_dbz;
          quo_q  <= is_dbz ? '1 : A;
          rem_q  <= is_dbz ? A : '0;
        end else begin
          quo_q <= a_mag;
          rem_q <= '0;
          div_q <= b_mag;
          cnt_q <= '0;
        end
      end
      if (state_q == RUN) begin
        quo_q <= {quo_q[N-2:0], ge};
        rem_q <= rem_nx;
        cnt_q <= last ? '0 : cnt_q + CW'(1);
      end
      if (state_q == FIX) begin
        done <= 1'b1;
        Q    <= q_fix;
        R    <= r_fix;
        dbz  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed vectors against an arithmetic reference model.
// Honours SEQ_DIVIDER_SIGNED_EN the same way the design does.
module tb_seq_divider;

  localparam int N = 8;

`ifdef SEQ_DIVIDER_SIGNED_EN
  localparam bit SG = 1'b1;
`else
  localparam bit SG = 1'b0;
`endif

  typedef struct {
    int         at;
    int         lat;
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
    logic       ovf;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       signed_mode;
  logic [7:0] A, B;
  logic       busy, done;
  logic [7:0] Q, R;
  logic       dbz, ovf;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   busy_end = 0;
  bit   cmp_en = 1'b0;
  exp_t eq[$];
  logic [7:0] hq = '0, hr = '0;
  logic       hdbz = 1'b0, hovf = 1'b0;

  seq_divider #(.N(N)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .signed_mode(signed_mode),
    .A(A),
    .B(B),
    .busy(busy),
    .done(done),
    .Q(Q),
    .R(R),
    .dbz(dbz),
    .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cyc %0d: got %0h want %0h",
               nm, cyc, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [7:0] a,
                                 input logic [7:0] b,
                                 input logic sm);
    exp_t e;
    int   ai, bi;
    bit   sg;
    sg    = SG && sm;
    e.at  = 0;
    e.lat = N + 1;
    e.dbz = 1'b0;
    e.ovf = 1'b0;
    if (b == 8'd0) begin
      e.q = 8'hFF; e.r = a;
      e.dbz = 1'b1; e.lat = 1;
    end else if (sg && a == 8'h80 && b == 8'hFF) begin
      e.q = 8'h80; e.r = 8'h00;
      e.ovf = 1'b1; e.lat = 1;
    end else if (sg) begin
      ai  = $signed(a);
      bi  = $signed(b);
      e.q = 8'(ai / bi);
      e.r = 8'(ai % bi);
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  // Reference: accept starts when idle, schedule the completion.
  always @(posedge clk or negedge reset) begin
    exp_t m;
    bit   idle;
    if (!reset) begin
      eq.delete();
      busy_end = 0;
      cyc = 0;
      hq = '0; hr = '0; hdbz = 1'b0; hovf = 1'b0;
    end else begin
      idle = !(cyc < busy_end);
      cyc++;
      if (start && idle) begin
        m = model(A, B, signed_mode);
        m.at = cyc + m.lat;
        if (m.lat != 1) busy_end = cyc + m.lat;
        eq.push_back(m);
      end
    end
  end

  // Every cycle: busy/done timing and held result values.
  always @(negedge clk) begin
    bit exp_done;
    if (cmp_en && reset) begin
      exp_done = 1'b0;
      if (eq.size() > 0 && eq[0].at == cyc) begin
        exp_done = 1'b1;
        hq = eq[0].q; hr = eq[0].r;
        hdbz = eq[0].dbz; hovf = eq[0].ovf;
        void'(eq.pop_front());
      end
      chk("busy", busy, cyc < busy_end);
      chk("done", done, exp_done);
      chk("Q", Q, hq);
      chk("R", R, hr);
      chk("dbz", dbz, hdbz);
      chk("ovf", ovf, hovf);
    end
  end

  task automatic wait_done(input int n0, output int n);
    n = n0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic op(input logic [7:0] a,
                    input logic [7:0] b,
                    input logic sm,
                    input logic [7:0] xq,
                    input logic [7:0] xr,
                    input logic xd,
                    input logic xo,
                    input int xl);
    int n;
    start = 1'b1; A = a; B = b; signed_mode = sm;
    @(negedge clk);
    start = 1'b0;
    A = 8'($urandom);
    B = 8'($urandom);
    signed_mode = 1'($urandom);
    wait_done(0, n);
    chk("lat", n, xl);
    chk("lit_Q", Q, xq);
    chk("lit_R", R, xr);
    chk("lit_dbz", dbz, xd);
    chk("lit_ovf", ovf, xo);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_Q"}, Q, 0);
    chk({tag, "_R"}, R, 0);
    chk({tag, "_dbz"}, dbz, 0);
    chk({tag, "_ovf"}, ovf, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n;
    reset = 1'b0; start = 1'b0;
    signed_mode = 1'b0; A = '0; B = '0;
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    chk_zero("rst");

    // First start lands on the first edge after release.
    reset = 1'b1;
    op(8'd200, 8'd7, 0, 8'd28, 8'd4, 0, 0, 9);
    op(8'd13, 8'd0, 0, 8'hFF, 8'd13, 1, 0, 1);
    op(8'hF9, 8'h02, 1,
       SG ? 8'hFD : 8'd124,
       SG ? 8'hFF : 8'd1, 0, 0, 9);
    op(8'h80, 8'hFF, 1,
       SG ? 8'h80 : 8'h00,
       SG ? 8'h00 : 8'h80,
       0, SG, SG ? 1 : 9);
    op(8'hFF, 8'h01, 0, 8'hFF, 8'h00, 0, 0, 9);
    op(8'd5, 8'd9, 0, 8'd0, 8'd5, 0, 0, 9);
    op(8'h80, 8'h01, 1, 8'h80, 8'h00, 0, 0, 9);
    op(8'h9C, 8'hF9, 1,
       SG ? 8'h0E : 8'h00,
       SG ? 8'hFE : 8'h9C, 0, 0, 9);
    op(8'h07, 8'hFE, 1,
       SG ? 8'hFD : 8'h00,
       SG ? 8'h01 : 8'h07, 0, 0, 9);
    op(8'h80, 8'h00, 1, 8'hFF, 8'h80, 1, 0, 1);

    // Restart while busy is ignored.
    @(negedge clk);
    start = 1'b1; A = 8'd100; B = 8'd3; signed_mode = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; A = 8'd9; B = 8'd9;
    @(negedge clk);
    start = 1'b0;
    wait_done(3, n);
    chk("ign_lat", n, 9);
    chk("ign_Q", Q, 8'd33);
    chk("ign_R", R, 8'd1);
    // Start raised in the done cycle.
    op(8'd9, 8'd9, 0, 8'd1, 8'd0, 0, 0, 9);

    // Reset in the middle of a run.
    @(negedge clk);
    start = 1'b1; A = 8'd100; B = 8'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    #1 chk_zero("abort");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    chk("abort_nodone_Q", Q, 8'd0);
    op(8'd50, 8'd5, 0, 8'd10, 8'd0, 0, 0, 9);

    repeat (3) @(negedge clk);
    chk("queue_empty", eq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
